// File: rtl/bus_xfer_seq_pkg.sv
// Shared bus code map, command/state encodings and code validity helpers
// used by the transfer sequencer and the datapath.
package bus_codes_pkg;

    localparam logic [4:0] BC_R0  = 5'd0,  BC_R1  = 5'd1,  BC_R2  = 5'd2,  BC_R3  = 5'd3;
    localparam logic [4:0] BC_R4  = 5'd4,  BC_R5  = 5'd5,  BC_R6  = 5'd6,  BC_R7  = 5'd7;
    localparam logic [4:0] BC_R8  = 5'd8,  BC_R9  = 5'd9,  BC_R10 = 5'd10, BC_R11 = 5'd11;
    localparam logic [4:0] BC_R12 = 5'd12, BC_R13 = 5'd13, BC_R14 = 5'd14, BC_R15 = 5'd15;
    localparam logic [4:0] BC_HI     = 5'd16;
    localparam logic [4:0] BC_LO     = 5'd17;
    localparam logic [4:0] BC_ZHI    = 5'd18;
    localparam logic [4:0] BC_ZLO    = 5'd19;
    localparam logic [4:0] BC_PC     = 5'd20;
    localparam logic [4:0] BC_MDR    = 5'd21;
    localparam logic [4:0] BC_IR     = 5'd22;
    localparam logic [4:0] BC_INPORT = 5'd23;
    localparam logic [4:0] BC_C      = 5'd24;
    localparam logic [4:0] SEL_NONE  = 5'd31;

    // Loadable registers occupy codes 0..22, one enable bit each.
    localparam int NUM_IN = 23;

    typedef enum logic [1:0] {
        OP_MOVE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_MAR_LD,
        S_ST_DATA,
        S_MEM_WAIT,
        S_MDR_OUT,
        S_DONE,
        S_ERR
    } state_t;

    function automatic logic valid_src(input logic [4:0] code);
        return code <= BC_C;
    endfunction

    // ZHI/ZLO are read-only ALU results; INPORT and C cannot be written.
    function automatic logic valid_dst(input logic [4:0] code);
        return (code <= BC_LO) || ((code >= BC_PC) && (code <= BC_IR));
    endfunction

endpackage

// File: rtl/bus_xfer_seq_if.sv
// Command, memory handshake and datapath control signals of the transfer
// sequencer; slave is the sequencer side, master the issuing side.
interface bus_xfer_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  src_sel;
    logic [4:0]  dst_sel;
    logic        mem_done;
    logic [4:0]  reg_out_select;
    logic [22:0] reg_in_en;
    logic        mar_in;
    logic        mdr_in;
    logic        mem_read;
    logic        mem_write;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, op, src_sel, dst_sel, mem_done,
        input  reg_out_select, reg_in_en, mar_in, mdr_in,
        input  mem_read, mem_write, busy, done, err
    );

    modport slave (
        input  start, op, src_sel, dst_sel, mem_done,
        output reg_out_select, reg_in_en, mar_in, mdr_in,
        output mem_read, mem_write, busy, done, err
    );
endinterface

// File: rtl/bus_xfer_seq_decoder.sv
// Bus code to one-hot register load enable; shared with the datapath.
module bus_in_decoder
    import bus_codes_pkg::*;
(
    input  logic [4:0]        code_i,
    input  logic              en_i,
    output logic [NUM_IN-1:0] onehot_o
);
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_bit
        assign onehot_o[gi] = en_i && (code_i == 5'(gi));
    end
endmodule

// File: rtl/bus_xfer_seq.sv
// Transfer sequencer: expands one MOVE/LOAD/STORE command into timed bus
// driver selects, load enables and a bounded memory handshake.
module bus_xfer_seq
    import bus_codes_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic           clock,
    input  logic           clear,
    bus_xfer_seq_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [4:0]       src_q, src_d, dst_q, dst_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0] sel_q, sel_d, in_code_q, in_code_d;
    logic       in_en_q, in_en_d, mar_q, mar_d, mdr_q, mdr_d;
    logic       rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: if (bus.start) begin
                op_d  = op_t'(bus.op);
                src_d = bus.src_sel;
                dst_d = bus.dst_sel;
                if (!valid_src(bus.src_sel)) begin
                    state_d = S_ERR;
                end else begin
                    case (op_t'(bus.op))
                        OP_MOVE:  state_d = valid_dst(bus.dst_sel) ? S_DRIVE  : S_ERR;
                        OP_LOAD:  state_d = valid_dst(bus.dst_sel) ? S_MAR_LD : S_ERR;
                        OP_STORE: state_d = valid_src(bus.dst_sel) ? S_MAR_LD : S_ERR;
                        default:  state_d = S_ERR;
                    endcase
                end
            end
            S_DRIVE:    state_d = S_DONE;
            S_MAR_LD:   state_d = (op_q == OP_LOAD) ? S_MEM_WAIT : S_ST_DATA;
            S_ST_DATA:  state_d = S_MEM_WAIT;
            S_MEM_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Completion is checked first so it beats the timeout cycle.
                if (bus.mem_done)
                    state_d = (op_q == OP_LOAD) ? S_MDR_OUT : S_DONE;
                else if (cnt_q == CNT_LAST)
                    state_d = S_ERR;
            end
            S_MDR_OUT:  state_d = S_DONE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are precomputed from the next state so they land registered.
    always_comb begin
        sel_d     = SEL_NONE;
        in_code_d = '0;
        in_en_d   = 1'b0;
        mar_d     = 1'b0;
        mdr_d     = 1'b0;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        busy_d    = (state_d != S_IDLE);
        case (state_d)
            S_DRIVE:    begin sel_d = src_d; in_en_d = 1'b1; in_code_d = dst_d; end
            S_MAR_LD:   begin sel_d = src_d; mar_d = 1'b1; end
            S_ST_DATA:  begin sel_d = dst_d; mdr_d = 1'b1; end
            S_MEM_WAIT: begin rd_d = (op_d == OP_LOAD); wr_d = (op_d == OP_STORE); end
            S_MDR_OUT:  begin sel_d = BC_MDR; in_en_d = 1'b1; in_code_d = dst_d; end
            S_DONE:     done_d = 1'b1;
            S_ERR:      begin done_d = 1'b1; err_d = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MOVE;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            sel_q     <= SEL_NONE;
            in_code_q <= '0;
            in_en_q   <= 1'b0;
            mar_q     <= 1'b0;
            mdr_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            in_code_q <= in_code_d;
            in_en_q   <= in_en_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    bus_in_decoder u_in_dec (
        .code_i   (in_code_q),
        .en_i     (in_en_q),
        .onehot_o (bus.reg_in_en)
    );

    assign bus.reg_out_select = sel_q;
    assign bus.mar_in         = mar_q;
    assign bus.mdr_in         = mdr_q;
    assign bus.mem_read       = rd_q;
    assign bus.mem_write      = wr_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq with a small datapath/memory responder.
module tb_bus_xfer_seq;
    logic clock = 1'b0;
    logic clear = 1'b0;
    logic dp_init = 1'b1;
    int   total = 0;
    int   bad   = 0;

    bus_xfer_seq_if bus();

    bus_xfer_seq #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // {mar_in, mdr_in, mem_read, mem_write, busy, done, err}
    localparam logic [6:0] F_IDLE = 7'b0000000;
    localparam logic [6:0] F_BUSY = 7'b0000100;
    localparam logic [6:0] F_MAR  = 7'b1000100;
    localparam logic [6:0] F_MDR  = 7'b0100100;
    localparam logic [6:0] F_RD   = 7'b0010100;
    localparam logic [6:0] F_WR   = 7'b0001100;
    localparam logic [6:0] F_DONE = 7'b0000110;
    localparam logic [6:0] F_ERR  = 7'b0000111;

    logic [6:0] flags;
    assign flags = {bus.mar_in, bus.mdr_in, bus.mem_read, bus.mem_write,
                    bus.busy, bus.done, bus.err};

    // Responder datapath: register file, MAR and a 4-word memory.
    logic [31:0] dp [0:31];
    logic [31:0] mem [0:3];
    logic [31:0] mar;
    logic [31:0] bus_val;
    always_comb bus_val = (bus.reg_out_select <= 5'd24) ? dp[bus.reg_out_select] : 32'h0;

    always @(posedge clock) begin
        if (dp_init) begin
            for (int n = 0; n < 32; n++) dp[n] <= 32'h0;
            for (int k = 0; k < 4; k++) mem[k] <= 32'h0;
            dp[20] <= 32'h12345678;
            dp[1]  <= 32'd2;
            dp[2]  <= 32'd1;
            dp[7]  <= 32'hDEADBEEF;
            mem[2] <= 32'hCAFEBABE;
            mar    <= 32'h0;
        end else begin
            for (int n = 0; n < 23; n++)
                if (bus.reg_in_en[n]) dp[n] <= bus_val;
            if (bus.mar_in) mar <= bus_val;
            if (bus.mdr_in) dp[21] <= bus_val;
            if (bus.mem_read && bus.mem_done) dp[21] <= mem[mar[1:0]];
            if (bus.mem_write && bus.mem_done) mem[mar[1:0]] <= dp[21];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [4:0] sel,
                              input logic [22:0] en, input logic [6:0] fl);
        chk({tag, ".sel"}, 32'(bus.reg_out_select), 32'(sel));
        chk({tag, ".en"}, 32'(bus.reg_in_en), 32'(en));
        chk({tag, ".flags"}, 32'(flags), 32'(fl));
    endtask

    task automatic cmd(input logic [1:0] o, input logic [4:0] s, input logic [4:0] d);
        $display("xfer op=%0d src=%0d dst=%0d at %0t", o, s, d, $time);
        bus.op      = o;
        bus.src_sel = s;
        bus.dst_sel = d;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.src_sel = 5'd0; bus.dst_sel = 5'd0;
        bus.mem_done = 1'b0;
        tick(); tick();
        expect_out("reset", 5'd31, 23'h0, F_IDLE);
        clear = 1'b1;
        dp_init = 1'b0;
        tick();

        // MOVE PC -> R3
        cmd(2'b00, 5'd20, 5'd3);
        expect_out("move.drive", 5'd20, 23'h000008, F_BUSY);
        tick();
        expect_out("move.done", 5'd31, 23'h0, F_DONE);
        chk("move.r3", dp[3], 32'h12345678);
        tick();
        expect_out("move.idle", 5'd31, 23'h0, F_IDLE);

        // LOAD [R1] -> R5, memory answers in the 4th wait cycle; start while busy ignored
        cmd(2'b01, 5'd1, 5'd5);
        expect_out("load.mar", 5'd1, 23'h0, F_MAR);
        tick();
        for (int i = 1; i <= 4; i++) begin
            expect_out($sformatf("load.wait%0d", i), 5'd31, 23'h0, F_RD);
            if (i == 2) begin
                bus.op = 2'b00; bus.src_sel = 5'd20; bus.dst_sel = 5'd3; bus.start = 1'b1;
            end
            if (i == 4) bus.mem_done = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        bus.mem_done = 1'b0;
        expect_out("load.mdr_out", 5'd21, 23'h000020, F_BUSY);
        tick();
        expect_out("load.done", 5'd31, 23'h0, F_DONE);
        chk("load.r5", dp[5], 32'hCAFEBABE);
        tick();
        expect_out("load.idle", 5'd31, 23'h0, F_IDLE);
        tick();
        expect_out("load.noqueue", 5'd31, 23'h0, F_IDLE);

        // STORE R7 -> [R2], memory answers in the first wait cycle
        cmd(2'b10, 5'd2, 5'd7);
        expect_out("store.mar", 5'd2, 23'h0, F_MAR);
        tick();
        expect_out("store.data", 5'd7, 23'h0, F_MDR);
        tick();
        expect_out("store.wait", 5'd31, 23'h0, F_WR);
        bus.mem_done = 1'b1;
        tick();
        bus.mem_done = 1'b0;
        expect_out("store.done", 5'd31, 23'h0, F_DONE);
        chk("store.mem1", mem[1], 32'hDEADBEEF);
        tick();
        expect_out("store.idle", 5'd31, 23'h0, F_IDLE);

        // LOAD with no memory answer: 16 wait cycles then abort
        cmd(2'b01, 5'd1, 5'd4);
        expect_out("tmo.mar", 5'd1, 23'h0, F_MAR);
        tick();
        for (int i = 0; i < 16; i++) begin
            expect_out($sformatf("tmo.wait%0d", i), 5'd31, 23'h0, F_RD);
            tick();
        end
        expect_out("tmo.err", 5'd31, 23'h0, F_ERR);
        tick();
        expect_out("tmo.idle", 5'd31, 23'h0, F_IDLE);

        // LOAD answered exactly on the timeout cycle completes normally
        cmd(2'b01, 5'd1, 5'd6);
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) bus.mem_done = 1'b1;
            tick();
        end
        bus.mem_done = 1'b0;
        expect_out("edge.mdr_out", 5'd21, 23'h000040, F_BUSY);
        tick();
        expect_out("edge.done", 5'd31, 23'h0, F_DONE);
        tick();

        // Reserved opcode and MOVE into read-only ZLO both abort immediately
        cmd(2'b11, 5'd0, 5'd0);
        expect_out("rsvd.err", 5'd31, 23'h0, F_ERR);
        tick();
        expect_out("rsvd.idle", 5'd31, 23'h0, F_IDLE);
        cmd(2'b00, 5'd0, 5'd19);
        expect_out("baddst.err", 5'd31, 23'h0, F_ERR);
        tick();

        // Asynchronous clear in MEM_WAIT idles outputs before the next edge
        cmd(2'b01, 5'd1, 5'd5);
        tick();
        expect_out("rst.wait", 5'd31, 23'h0, F_RD);
        #2 clear = 1'b0;
        #1;
        expect_out("rst.async", 5'd31, 23'h0, F_IDLE);
        tick();
        clear = 1'b1;
        tick();
        expect_out("rst.idle", 5'd31, 23'h0, F_IDLE);
        cmd(2'b00, 5'd20, 5'd2);
        expect_out("rst.move.drive", 5'd20, 23'h000004, F_BUSY);
        tick();
        expect_out("rst.move.done", 5'd31, 23'h0, F_DONE);
        chk("rst.move.r2", dp[2], 32'h12345678);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
